// File: rtl/cpu_bus_seq.sv
// Byte-serial CPU bus sequencer. It splits one read or write of up to MAX_BYTES
// bytes into single-byte bus accesses and assembles a little-endian read result.
module cpu_bus_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 24,
  parameter int MAX_BYTES  = 3,
  parameter int LEN_WIDTH  = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable,
  input  logic                            start,
  input  logic                            start_which,
  input  logic [ADDR_WIDTH-1:0]           start_addr,
  input  logic [LEN_WIDTH-1:0]            start_len,
  input  logic                            bank_wrap,
  input  logic [MAX_BYTES*DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0]           data_in,
  input  logic                            bus_ack,
  output logic                            req_rdwr,
  output logic                            which_rdwr,
  output logic [ADDR_WIDTH-1:0]           addr,
  output logic [DATA_WIDTH-1:0]           data_out,
  output logic                            busy,
  output logic                            done,
  output logic [MAX_BYTES*DATA_WIDTH-1:0] rd_data
);

  localparam int BUF_W = MAX_BYTES * DATA_WIDTH;
  localparam logic [LEN_WIDTH-1:0]  MAX_LEN = LEN_WIDTH'(MAX_BYTES);
  localparam logic [LEN_WIDTH-1:0]  ONE_L   = LEN_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic                    r_req, w_req_nxt;
  logic                    r_which, w_which_nxt;
  logic [ADDR_WIDTH-1:0]   r_addr, w_addr_nxt;
  logic [DATA_WIDTH-1:0]   r_dout, w_dout_nxt;
  logic                    r_busy, w_busy_nxt;
  logic                    r_done, w_done_nxt;
  logic [BUF_W-1:0]        r_rd, w_rd_nxt;
  logic [BUF_W-1:0]        r_wbuf, w_wbuf_nxt;
  logic                    r_wrap, w_wrap_nxt;
  logic [LEN_WIDTH-1:0]    r_last, w_last_nxt;
  logic [LEN_WIDTH-1:0]    r_idx, w_idx_nxt;

  logic [LEN_WIDTH-1:0]    w_last_start;
  logic [LEN_WIDTH-1:0]    w_idx_inc;
  logic [ADDR_WIDTH-1:0]   w_addr_inc;

  // The length is stored as "index of the last byte" so the XFER compare is direct.
  always_comb begin
    if (start_len == '0) begin
      w_last_start = '0;
    end else if (start_len > MAX_LEN) begin
      w_last_start = MAX_LEN - ONE_L;
    end else begin
      w_last_start = start_len - ONE_L;
    end
  end

  assign w_idx_inc  = r_idx + ONE_L;
  assign w_addr_inc = r_wrap ? {r_addr[ADDR_WIDTH-1:16], r_addr[15:0] + 16'd1}
                             : r_addr + ONE_A;

  // NOTE: every next-state signal takes its held value first, so no path through
  // the case below can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_which_nxt = r_which;
    w_addr_nxt  = r_addr;
    w_dout_nxt  = r_dout;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;
    w_rd_nxt    = r_rd;
    w_wbuf_nxt  = r_wbuf;
    w_wrap_nxt  = r_wrap;
    w_last_nxt  = r_last;
    w_idx_nxt   = r_idx;

    unique case (r_state)
      S_IDLE: begin
        w_done_nxt = 1'b0;
        if (start) begin
          w_state_nxt = S_XFER;
          w_which_nxt = start_which;
          w_addr_nxt  = start_addr;
          w_wrap_nxt  = bank_wrap;
          w_last_nxt  = w_last_start;
          w_wbuf_nxt  = wr_data;
          w_rd_nxt    = '0;
          w_idx_nxt   = '0;
          w_req_nxt   = 1'b1;
          w_busy_nxt  = 1'b1;
          w_dout_nxt  = start_which ? wr_data[DATA_WIDTH-1:0] : '0;
        end
      end

      S_XFER: begin
        if (bus_ack) begin
          if (!r_which) begin
            w_rd_nxt[int'(r_idx)*DATA_WIDTH +: DATA_WIDTH] = data_in;
          end
          w_addr_nxt = w_addr_inc;
          if (r_idx == r_last) begin
            // Last byte: drop the request on this same edge and pulse done next.
            w_state_nxt = S_DONE;
            w_req_nxt   = 1'b0;
            w_dout_nxt  = '0;
            w_done_nxt  = 1'b1;
          end else begin
            w_idx_nxt  = w_idx_inc;
            w_dout_nxt = r_which ? r_wbuf[int'(w_idx_inc)*DATA_WIDTH +: DATA_WIDTH] : '0;
          end
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_done_nxt  = 1'b0;
        w_busy_nxt  = 1'b0;
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_req_nxt   = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
      end
    endcase
  end

  // NOTE: the write buffer and read assembly register are plain flops, so they
  // are cleared with everything else; a reset mid-transfer leaves nothing stale.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_which <= 1'b0;
      r_addr  <= '0;
      r_dout  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rd    <= '0;
      r_wbuf  <= '0;
      r_wrap  <= 1'b0;
      r_last  <= '0;
      r_idx   <= '0;
    end else if (enable) begin
      // NOTE: non-blocking updates so every flop samples the pre-edge values.
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_which <= w_which_nxt;
      r_addr  <= w_addr_nxt;
      r_dout  <= w_dout_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_rd    <= w_rd_nxt;
      r_wbuf  <= w_wbuf_nxt;
      r_wrap  <= w_wrap_nxt;
      r_last  <= w_last_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  assign req_rdwr   = r_req;
  assign which_rdwr = r_which;
  assign addr       = r_addr;
  assign data_out   = r_dout;
  assign busy       = r_busy;
  assign done       = r_done;
  assign rd_data    = r_rd;

endmodule

// File: tb/tb_cpu_bus_seq.sv
// Directed bench for cpu_bus_seq: a bus responder with programmable wait states
// feeds each transaction; logged addresses, data and timing are compared to hand values.
module tb_cpu_bus_seq;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        start;
  logic        start_which;
  logic [23:0] start_addr;
  logic [2:0]  start_len;
  logic        bank_wrap;
  logic [23:0] wr_data;
  logic [7:0]  data_in;
  logic        bus_ack;
  logic        req_rdwr;
  logic        which_rdwr;
  logic [23:0] addr;
  logic [7:0]  data_out;
  logic        busy;
  logic        done;
  logic [23:0] rd_data;

  int total;
  int bad;

  // Results of the most recent run_txn call.
  int          acc_cnt;
  logic [23:0] addr_log [0:7];
  logic [7:0]  dout_log [0:7];
  int          which_bad;
  int          wait_seen;
  int          done_cyc;
  int          done_cnt;
  logic [23:0] rd_at_done;
  logic [23:0] rd_after;

  cpu_bus_seq #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(24),
    .MAX_BYTES (3),
    .LEN_WIDTH (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .start      (start),
    .start_which(start_which),
    .start_addr (start_addr),
    .start_len  (start_len),
    .bank_wrap  (bank_wrap),
    .wr_data    (wr_data),
    .data_in    (data_in),
    .bus_ack    (bus_ack),
    .req_rdwr   (req_rdwr),
    .which_rdwr (which_rdwr),
    .addr       (addr),
    .data_out   (data_out),
    .busy       (busy),
    .done       (done),
    .rd_data    (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issues one transaction and plays the memory side. Inputs change on the
  // falling edge, outputs are observed there too. Cycle 1 is the cycle after
  // the edge that samples start.
  task automatic run_txn(input logic wh, input logic [23:0] a, input logic [2:0] len,
                         input logic wrap, input logic [23:0] wd, input logic [23:0] mem,
                         input int waits, input logic poke);
    int cyc;
    int wctr;
    bit finished;
    acc_cnt   = 0;
    which_bad = 0;
    wait_seen = 0;
    done_cyc  = -1;
    done_cnt  = 0;
    wctr      = 0;
    finished  = 1'b0;
    cyc       = 0;
    for (int i = 0; i < 8; i++) begin
      addr_log[i] = '0;
      dout_log[i] = '0;
    end
    @(negedge clk);
    start       = 1'b1;
    start_which = wh;
    start_addr  = a;
    start_len   = len;
    bank_wrap   = wrap;
    wr_data     = wd;
    bus_ack     = 1'b0;
    while (!finished && cyc < 60) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      start   = poke && (cyc == 2);
      if (start) begin
        start_addr = 24'h555555;
        start_len  = 3'd3;
      end
      bus_ack = 1'b0;
      if (req_rdwr) begin
        if (wctr < waits) begin
          wctr++;
          wait_seen++;
        end else begin
          bus_ack = 1'b1;
          data_in = (acc_cnt < 3) ? mem[acc_cnt*8 +: 8] : 8'h00;
          if (acc_cnt < 8) begin
            addr_log[acc_cnt] = addr;
            dout_log[acc_cnt] = data_out;
          end
          if (which_rdwr !== wh) which_bad++;
          acc_cnt++;
          wctr = 0;
        end
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc   = cyc;
          rd_at_done = rd_data;
        end
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) finished = 1'b1;
    end
    if (!finished) check("txn_timeout", 64'd0, 64'd1);
    rd_after = rd_data;
    start    = 1'b0;
    bus_ack  = 1'b0;
  endtask

  initial begin
    int late_done;
    total       = 0;
    bad         = 0;
    rst         = 1'b0;
    enable      = 1'b0;
    start       = 1'b0;
    start_which = 1'b0;
    start_addr  = '0;
    start_len   = '0;
    bank_wrap   = 1'b0;
    wr_data     = '0;
    data_in     = '0;
    bus_ack     = 1'b0;

    // Reset with enable low still clears everything.
    repeat (3) @(negedge clk);
    check("rst_req",   {63'd0, req_rdwr},   64'd0);
    check("rst_which", {63'd0, which_rdwr}, 64'd0);
    check("rst_addr",  {40'd0, addr},       64'd0);
    check("rst_dout",  {56'd0, data_out},   64'd0);
    check("rst_busy",  {63'd0, busy},       64'd0);
    check("rst_done",  {63'd0, done},       64'd0);
    check("rst_rd",    {40'd0, rd_data},    64'd0);
    rst    = 1'b1;
    enable = 1'b1;
    @(negedge clk);

    // 3-byte read across a bank boundary, bank wrap on.
    run_txn(1'b0, 24'h12FFFE, 3'd3, 1'b1, 24'h0, 24'hCCBBAA, 0, 1'b0);
    check("rdw_acc",   acc_cnt,     3);
    check("rdw_a0",    addr_log[0], 24'h12FFFE);
    check("rdw_a1",    addr_log[1], 24'h12FFFF);
    check("rdw_a2",    addr_log[2], 24'h120000);
    check("rdw_dout",  {dout_log[0], dout_log[1], dout_log[2]}, 24'h0);
    check("rdw_which", which_bad,   0);
    check("rdw_rd",    rd_at_done,  24'hCCBBAA);
    check("rdw_lat",   done_cyc,    4);
    check("rdw_ndone", done_cnt,    1);
    check("rdw_hold",  rd_after,    24'hCCBBAA);
    check("rdw_busy",  {63'd0, busy}, 64'd0);

    // Same read, full-address increment.
    run_txn(1'b0, 24'h12FFFE, 3'd3, 1'b0, 24'h0, 24'hCCBBAA, 0, 1'b0);
    check("rdf_a1",    addr_log[1], 24'h12FFFF);
    check("rdf_a2",    addr_log[2], 24'h130000);
    check("rdf_rd",    rd_at_done,  24'hCCBBAA);

    // 2-byte write wrapping the full address space, 2 wait states per byte.
    run_txn(1'b1, 24'hFFFFFF, 3'd2, 1'b0, 24'h003412, 24'h0, 2, 1'b0);
    check("wr_acc",    acc_cnt,     2);
    check("wr_a0",     addr_log[0], 24'hFFFFFF);
    check("wr_a1",     addr_log[1], 24'h000000);
    check("wr_d0",     dout_log[0], 8'h12);
    check("wr_d1",     dout_log[1], 8'h34);
    check("wr_which",  which_bad,   0);
    check("wr_waits",  wait_seen,   4);
    check("wr_lat",    done_cyc,    7);
    check("wr_rd",     rd_at_done,  24'h0);
    check("wr_ndone",  done_cnt,    1);

    // Zero length is one byte.
    run_txn(1'b0, 24'h000100, 3'd0, 1'b0, 24'h0, 24'h000099, 0, 1'b0);
    check("len0_acc",  acc_cnt,     1);
    check("len0_rd",   rd_at_done,  24'h000099);
    check("len0_lat",  done_cyc,    2);

    // Oversized length clamps to 3; a start while busy is dropped.
    run_txn(1'b0, 24'h000200, 3'd5, 1'b0, 24'h0, 24'h332211, 0, 1'b1);
    check("len5_acc",  acc_cnt,     3);
    check("len5_a2",   addr_log[2], 24'h000202);
    check("len5_rd",   rd_at_done,  24'h332211);
    check("len5_ndone", done_cnt,   1);
    check("len5_idle", {63'd0, req_rdwr}, 64'd0);

    // Freeze mid-transfer with ack held high, then reset mid-transfer.
    @(negedge clk);
    start       = 1'b1;
    start_which = 1'b0;
    start_addr  = 24'h000010;
    start_len   = 3'd3;
    bank_wrap   = 1'b0;
    @(negedge clk);
    start   = 1'b0;
    bus_ack = 1'b1;
    data_in = 8'h5A;
    @(negedge clk);
    enable  = 1'b0;
    data_in = 8'h77;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("frz_addr", {40'd0, addr},     {40'd0, 24'h000011});
      check("frz_rd",   {40'd0, rd_data},  {40'd0, 24'h00005A});
      check("frz_req",  {63'd0, req_rdwr}, 64'd1);
    end
    enable  = 1'b1;
    data_in = 8'h66;
    @(negedge clk);
    check("frz_addr2", {40'd0, addr},    {40'd0, 24'h000012});
    check("frz_rd2",   {40'd0, rd_data}, {40'd0, 24'h00665A});
    rst     = 1'b0;
    data_in = 8'hEE;
    @(negedge clk);
    check("abort_req",  {63'd0, req_rdwr},   64'd0);
    check("abort_addr", {40'd0, addr},       64'd0);
    check("abort_rd",   {40'd0, rd_data},    64'd0);
    check("abort_busy", {63'd0, busy},       64'd0);
    check("abort_done", {63'd0, done},       64'd0);
    check("abort_which", {63'd0, which_rdwr}, 64'd0);
    check("abort_dout", {56'd0, data_out},   64'd0);
    rst     = 1'b1;
    bus_ack = 1'b0;
    late_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1 || req_rdwr === 1'b1) late_done++;
    end
    check("abort_quiet", late_done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
